hazard_controller: RTL and testbench
====================================

# hazard_controller

Pipeline sequencing controller for the 5-stage core. Decides every cycle whether each stage register advances, holds, or is flushed. It covers three cases: load-use stalls, taken-branch flushes, and multi-cycle multiply/divide (MDU) occupancy of EX. It sits beside the forwarding logic in ID/EX: forwarding resolves ALU-to-ALU dependences, and this block handles everything forwarding cannot.

## Interface
- REG_ADDR_WIDTH, 5, register address width
- MDU_LATENCY, 4, cycles an MDU instruction occupies EX; legal range 1..16

- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- id_rs1_i  in  REG_ADDR_WIDTH  rs1 of instruction in ID
- id_rs2_i  in  REG_ADDR_WIDTH  rs2 of instruction in ID
- id_uses_rs1_i  in  1  ID instruction reads rs1
- id_uses_rs2_i  in  1  ID instruction reads rs2
- ex_rd_i  in  REG_ADDR_WIDTH  rd of instruction in EX
- ex_mem_read_i  in  1  EX instruction is a load
- ex_mdu_i  in  1  EX instruction is multiply/divide
- ex_branch_taken_i  in  1  EX branch/jump resolved taken
- pc_write_o  out  1  PC update enable
- if_id_write_o  out  1  IF/ID load enable
- if_id_flush_o  out  1  IF/ID cleared to NOP
- id_ex_write_o  out  1  ID/EX load enable
- id_ex_flush_o  out  1  ID/EX cleared to NOP
- ex_mem_flush_o  out  1  bubble into EX/MEM
- mdu_busy_o  out  1  MDU operation in progress
- mdu_done_o  out  1  MDU result valid this cycle
- stall_cnt_o  out  16  saturating count of stall cycles

## Operation
- States: RUN, MDU_WAIT. The block holds a down-counter cnt of width clog2(MDU_LATENCY), minimum 1 bit.
- Default outputs in RUN:
  - pc_write_o = if_id_write_o = id_ex_write_o = 1
  - all flush outputs = 0, mdu_busy_o = 0, mdu_done_o = 0
- RUN, priority order (first match wins):
  1. Branch: ex_branch_taken_i=1. if_id_flush_o=1, id_ex_flush_o=1; PC still writes (target). Wins over everything, including a simultaneous ex_mdu_i (treated as a flushed wrong-path condition, no MDU entry).
  2. MDU entry: ex_mdu_i=1 and MDU_LATENCY>1.
     - Outputs: pc_write_o=0, if_id_write_o=0, id_ex_write_o=0, ex_mem_flush_o=1, mdu_busy_o=1.
     - Next state MDU_WAIT, cnt <= MDU_LATENCY-2.
     - With MDU_LATENCY=1, assert mdu_done_o=1 in the same cycle and stay in RUN with no stall.
  3. Load-use: ex_mem_read_i=1, ex_rd_i!=0, and (id_uses_rs1_i and id_rs1_i==ex_rd_i, or id_uses_rs2_i and id_rs2_i==ex_rd_i).
     - Outputs: pc_write_o=0, if_id_write_o=0, id_ex_flush_o=1.
     - Single cycle; the condition re-evaluates next cycle.
- MDU_WAIT:
  - cnt != 0: same hold outputs as MDU entry; cnt decrements.
  - cnt == 0 (release cycle): default RUN outputs plus mdu_busy_o=1, mdu_done_o=1; next state RUN.
  - ex_branch_taken_i, ex_mem_read_i and the ID inputs are ignored for the whole of MDU_WAIT.
- Stall cycle: any cycle with pc_write_o=0. stall_cnt_o increments on each stall cycle and saturates at 16'hFFFF; it never wraps.

## Timing
- All outputs except stall_cnt_o are combinational from state, cnt and inputs. stall_cnt_o is registered.
- While rst_i=1 (asynchronous):
  - state=RUN, cnt=0, stall_cnt_o=0
  - all write enables, flushes, mdu_busy_o and mdu_done_o forced to 0
- First cycle after reset release: default RUN outputs.
- MDU instruction occupies EX for exactly MDU_LATENCY cycles: 1 entry cycle, MDU_LATENCY-2 wait cycles, 1 release cycle. It causes MDU_LATENCY-1 stall cycles.
- Back-to-back MDU: the next EX instruction's ex_mdu_i is sampled in RUN on the cycle after release and re-enters immediately.
- Reset mid-MDU_WAIT aborts the operation: RUN, counter cleared, no mdu_done_o.
- Load-use stall costs exactly 1 cycle. The load has moved to MEM by the next cycle, and forwarding covers the rest.
- rd = x0 never causes a stall.

## Test plan
- Reset: assert rst_i with ex_mdu_i=1 -> all outputs 0, stall_cnt_o=0; after release -> pc_write_o=if_id_write_o=id_ex_write_o=1.
- Load-use: ex_mem_read_i=1, ex_rd_i=5, id_rs2_i=5, id_uses_rs2_i=1 -> one cycle of pc_write_o=0, if_id_write_o=0, id_ex_flush_o=1; stall_cnt_o=1. Repeat with ex_rd_i=0 -> no stall.
- MDU, MDU_LATENCY=4: ex_mdu_i=1 for one RUN cycle, then held -> 3 cycles of pc_write_o=0, ex_mem_flush_o=1, mdu_busy_o=1, then 1 release cycle with mdu_done_o=1; stall_cnt_o=3.
- Branch priority: ex_branch_taken_i=1 together with a matching load-use -> if_id_flush_o=1, id_ex_flush_o=1, pc_write_o=1, no stall.
- Reset mid-MDU: rst_i pulsed in the second wait cycle -> immediate RUN, mdu_done_o never asserts, stall_cnt_o=0.
- Saturation: force 65,540 load-use cycles -> stall_cnt_o stays at 16'hFFFF.

Source files
------------

// File: rtl/hazard_controller_if.sv
// Hazard controller bundle: ID/EX hazard inputs toward the controller and
// stage-register enables, flushes and MDU status back from it.
interface hazard_controller_if #(
  parameter int REG_ADDR_WIDTH = 5
);
  logic [REG_ADDR_WIDTH-1:0] id_rs1_i;
  logic [REG_ADDR_WIDTH-1:0] id_rs2_i;
  logic                      id_uses_rs1_i;
  logic                      id_uses_rs2_i;
  logic [REG_ADDR_WIDTH-1:0] ex_rd_i;
  logic                      ex_mem_read_i;
  logic                      ex_mdu_i;
  logic                      ex_branch_taken_i;
  logic                      pc_write_o;
  logic                      if_id_write_o;
  logic                      if_id_flush_o;
  logic                      id_ex_write_o;
  logic                      id_ex_flush_o;
  logic                      ex_mem_flush_o;
  logic                      mdu_busy_o;
  logic                      mdu_done_o;
  logic [15:0]               stall_cnt_o;

  // Pipeline side: drives hazard information, consumes control decisions.
  modport master (
    output id_rs1_i, id_rs2_i, id_uses_rs1_i, id_uses_rs2_i,
    output ex_rd_i, ex_mem_read_i, ex_mdu_i, ex_branch_taken_i,
    input  pc_write_o, if_id_write_o, if_id_flush_o, id_ex_write_o,
    input  id_ex_flush_o, ex_mem_flush_o, mdu_busy_o, mdu_done_o, stall_cnt_o
  );

  // Controller side.
  modport slave (
    input  id_rs1_i, id_rs2_i, id_uses_rs1_i, id_uses_rs2_i,
    input  ex_rd_i, ex_mem_read_i, ex_mdu_i, ex_branch_taken_i,
    output pc_write_o, if_id_write_o, if_id_flush_o, id_ex_write_o,
    output id_ex_flush_o, ex_mem_flush_o, mdu_busy_o, mdu_done_o, stall_cnt_o
  );
endinterface

// File: rtl/hazard_controller.sv
// Pipeline sequencing controller for the 5-stage core: load-use stalls,
// taken-branch flushes and multi-cycle MDU occupancy of EX. All controls are
// combinational from state/counter/inputs; only the stall counter is registered.
module hazard_controller #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MDU_LATENCY    = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  hazard_controller_if.slave bus
);

  localparam int CNT_W = (MDU_LATENCY > 1) ? $clog2(MDU_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((MDU_LATENCY > 1) ? (MDU_LATENCY - 2) : 0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [REG_ADDR_WIDTH-1:0] REG_X0 = '0;

  localparam logic [0:0] ST_RUN      = 1'b0;
  localparam logic [0:0] ST_MDU_WAIT = 1'b1;

  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [15:0]      r_stall_cnt;

  logic [0:0]       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_load_use;
  logic             w_pc_write;
  logic             w_if_id_write;
  logic             w_if_id_flush;
  logic             w_id_ex_write;
  logic             w_id_ex_flush;
  logic             w_ex_mem_flush;
  logic             w_mdu_busy;
  logic             w_mdu_done;

  // Load-use hazard: a load in EX writes a non-x0 register the ID instruction reads.
  assign w_load_use = bus.ex_mem_read_i && (bus.ex_rd_i != REG_X0) &&
                      ((bus.id_uses_rs1_i && (bus.id_rs1_i == bus.ex_rd_i)) ||
                       (bus.id_uses_rs2_i && (bus.id_rs2_i == bus.ex_rd_i)));

  // Next-state and control decode; reset forces every control low.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_pc_write     = 1'b0;
    w_if_id_write  = 1'b0;
    w_if_id_flush  = 1'b0;
    w_id_ex_write  = 1'b0;
    w_id_ex_flush  = 1'b0;
    w_ex_mem_flush = 1'b0;
    w_mdu_busy     = 1'b0;
    w_mdu_done     = 1'b0;
    if (rst_i) begin
      w_state_nxt = ST_RUN;
      w_cnt_nxt   = CNT_ZERO;
    end else begin
      case (r_state)
        ST_RUN: begin
          w_pc_write    = 1'b1;
          w_if_id_write = 1'b1;
          w_id_ex_write = 1'b1;
          if (bus.ex_branch_taken_i) begin
            // Wrong-path instructions in IF/ID and ID/EX are squashed; any MDU op
            // in EX at the same time is on the wrong path and never starts.
            w_if_id_flush = 1'b1;
            w_id_ex_flush = 1'b1;
          end else if (bus.ex_mdu_i) begin
            if (MDU_LATENCY > 1) begin
              w_pc_write     = 1'b0;
              w_if_id_write  = 1'b0;
              w_id_ex_write  = 1'b0;
              w_ex_mem_flush = 1'b1;
              w_mdu_busy     = 1'b1;
              w_state_nxt    = ST_MDU_WAIT;
              w_cnt_nxt      = CNT_LOAD;
            end else begin
              w_mdu_done = 1'b1;
            end
          end else if (w_load_use) begin
            w_pc_write    = 1'b0;
            w_if_id_write = 1'b0;
            w_id_ex_flush = 1'b1;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_MDU_WAIT: begin
          if (r_cnt != CNT_ZERO) begin
            w_ex_mem_flush = 1'b1;
            w_mdu_busy     = 1'b1;
            w_cnt_nxt      = r_cnt - CNT_ONE;
          end else begin
            // Release cycle: pipeline advances while the result is presented.
            w_pc_write    = 1'b1;
            w_if_id_write = 1'b1;
            w_id_ex_write = 1'b1;
            w_mdu_busy    = 1'b1;
            w_mdu_done    = 1'b1;
            w_state_nxt   = ST_RUN;
          end
        end
        default: begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = CNT_ZERO;
        end
      endcase
    end
  end

  // State and MDU down-counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_RUN;
      r_cnt   <= CNT_ZERO;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Saturating count of cycles in which the PC was held.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stall_cnt <= 16'h0000;
    end else if (!w_pc_write && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'h0001;
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end

  assign bus.pc_write_o     = w_pc_write;
  assign bus.if_id_write_o  = w_if_id_write;
  assign bus.if_id_flush_o  = w_if_id_flush;
  assign bus.id_ex_write_o  = w_id_ex_write;
  assign bus.id_ex_flush_o  = w_id_ex_flush;
  assign bus.ex_mem_flush_o = w_ex_mem_flush;
  assign bus.mdu_busy_o     = w_mdu_busy;
  assign bus.mdu_done_o     = w_mdu_done;
  assign bus.stall_cnt_o    = r_stall_cnt;

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed scenarios with literal
// expectations plus randomized traffic compared every cycle to a behavioural model.
module tb_hazard_controller;

  localparam int LAT = 4;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  hazard_controller_if #(.REG_ADDR_WIDTH(5)) bus ();

  hazard_controller #(.REG_ADDR_WIDTH(5), .MDU_LATENCY(LAT)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_pos: which cycle (1..LAT) of an MDU occupancy the previous cycle was in
  // carried forward; 0 means EX is not occupied by an MDU op.
  int m_pos   = 0;
  int m_stall = 0;

  always @(negedge clk_i) begin
    int p;
    bit e_pc, e_ifw, e_iff, e_idw, e_idf, e_emf, e_busy, e_done, lu;
    if (rst_i) begin
      check("m_rst_pc", bus.pc_write_o, 32'd0);
      check("m_rst_ifw", bus.if_id_write_o, 32'd0);
      check("m_rst_idw", bus.id_ex_write_o, 32'd0);
      check("m_rst_iff", bus.if_id_flush_o, 32'd0);
      check("m_rst_idf", bus.id_ex_flush_o, 32'd0);
      check("m_rst_emf", bus.ex_mem_flush_o, 32'd0);
      check("m_rst_busy", bus.mdu_busy_o, 32'd0);
      check("m_rst_done", bus.mdu_done_o, 32'd0);
      check("m_rst_cnt", bus.stall_cnt_o, 32'd0);
      m_pos   = 0;
      m_stall = 0;
    end else begin
      lu = bus.ex_mem_read_i && (bus.ex_rd_i != 0) &&
           ((bus.id_uses_rs1_i && bus.id_rs1_i == bus.ex_rd_i) ||
            (bus.id_uses_rs2_i && bus.id_rs2_i == bus.ex_rd_i));
      p = m_pos;
      if (p == 0 && !bus.ex_branch_taken_i && bus.ex_mdu_i && LAT > 1) p = 1;
      {e_pc, e_ifw, e_iff, e_idw, e_idf, e_emf, e_busy, e_done} = '0;
      if (p == 0) begin
        e_pc = 1; e_ifw = 1; e_idw = 1;
        if (bus.ex_branch_taken_i) begin
          e_iff = 1; e_idf = 1;
        end else if (bus.ex_mdu_i) begin
          e_done = 1;  // only reachable with single-cycle MDU
        end else if (lu) begin
          e_pc = 0; e_ifw = 0; e_idf = 1;
        end
      end else if (p < LAT) begin
        e_emf = 1; e_busy = 1;
      end else begin
        e_pc = 1; e_ifw = 1; e_idw = 1; e_busy = 1; e_done = 1;
      end
      check("pc_write", bus.pc_write_o, {31'd0, e_pc});
      check("if_id_write", bus.if_id_write_o, {31'd0, e_ifw});
      check("if_id_flush", bus.if_id_flush_o, {31'd0, e_iff});
      check("id_ex_write", bus.id_ex_write_o, {31'd0, e_idw});
      check("id_ex_flush", bus.id_ex_flush_o, {31'd0, e_idf});
      check("ex_mem_flush", bus.ex_mem_flush_o, {31'd0, e_emf});
      check("mdu_busy", bus.mdu_busy_o, {31'd0, e_busy});
      check("mdu_done", bus.mdu_done_o, {31'd0, e_done});
      check("stall_cnt", bus.stall_cnt_o, m_stall);
      if (!e_pc && m_stall < 65535) m_stall++;
      m_pos = (p == 0 || p == LAT) ? 0 : p + 1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clr();
    bus.id_rs1_i = 5'd0; bus.id_rs2_i = 5'd0;
    bus.id_uses_rs1_i = 1'b0; bus.id_uses_rs2_i = 1'b0;
    bus.ex_rd_i = 5'd0; bus.ex_mem_read_i = 1'b0;
    bus.ex_mdu_i = 1'b0; bus.ex_branch_taken_i = 1'b0;
  endtask

  task automatic rst_pulse();
    tick(); clr(); rst_i = 1'b1;
    tick(); rst_i = 1'b0;
  endtask

  initial begin
    // Reset with an MDU op present: everything low.
    clr();
    bus.ex_mdu_i = 1'b1;
    @(negedge clk_i);
    check("rst_pc", bus.pc_write_o, 32'd0);
    check("rst_busy", bus.mdu_busy_o, 32'd0);
    check("rst_emf", bus.ex_mem_flush_o, 32'd0);
    check("rst_cnt", bus.stall_cnt_o, 32'd0);
    tick(); rst_i = 1'b0; bus.ex_mdu_i = 1'b0;
    @(negedge clk_i);
    check("run_pc", bus.pc_write_o, 32'd1);
    check("run_ifw", bus.if_id_write_o, 32'd1);
    check("run_idw", bus.id_ex_write_o, 32'd1);

    // Load-use on rs2 = x5.
    tick();
    bus.ex_mem_read_i = 1'b1; bus.ex_rd_i = 5'd5; bus.id_rs2_i = 5'd5; bus.id_uses_rs2_i = 1'b1;
    @(negedge clk_i);
    check("lu_pc", bus.pc_write_o, 32'd0);
    check("lu_ifw", bus.if_id_write_o, 32'd0);
    check("lu_idf", bus.id_ex_flush_o, 32'd1);
    tick(); clr();
    @(negedge clk_i);
    check("lu_cnt", bus.stall_cnt_o, 32'd1);
    check("lu_after_pc", bus.pc_write_o, 32'd1);
    // Same pattern against x0: no stall.
    tick();
    bus.ex_mem_read_i = 1'b1; bus.ex_rd_i = 5'd0; bus.id_rs2_i = 5'd0; bus.id_uses_rs2_i = 1'b1;
    @(negedge clk_i);
    check("x0_pc", bus.pc_write_o, 32'd1);
    check("x0_idf", bus.id_ex_flush_o, 32'd0);
    tick(); clr();
    @(negedge clk_i);
    check("x0_cnt", bus.stall_cnt_o, 32'd1);

    // MDU occupancy with ex_mdu_i held throughout.
    rst_pulse();
    bus.ex_mdu_i = 1'b1;
    for (int k = 1; k < LAT; k++) begin
      @(negedge clk_i);
      check("mdu_hold_pc", bus.pc_write_o, 32'd0);
      check("mdu_hold_emf", bus.ex_mem_flush_o, 32'd1);
      check("mdu_hold_busy", bus.mdu_busy_o, 32'd1);
      check("mdu_hold_done", bus.mdu_done_o, 32'd0);
      tick();
    end
    @(negedge clk_i);
    check("mdu_rel_done", bus.mdu_done_o, 32'd1);
    check("mdu_rel_busy", bus.mdu_busy_o, 32'd1);
    check("mdu_rel_pc", bus.pc_write_o, 32'd1);
    check("mdu_rel_emf", bus.ex_mem_flush_o, 32'd0);
    tick(); bus.ex_mdu_i = 1'b0;
    @(negedge clk_i);
    check("mdu_cnt", bus.stall_cnt_o, 32'd3);
    check("mdu_idle_busy", bus.mdu_busy_o, 32'd0);

    // Branch wins over a matching load-use.
    tick();
    bus.ex_branch_taken_i = 1'b1; bus.ex_mem_read_i = 1'b1; bus.ex_rd_i = 5'd7;
    bus.id_rs1_i = 5'd7; bus.id_uses_rs1_i = 1'b1;
    @(negedge clk_i);
    check("br_iff", bus.if_id_flush_o, 32'd1);
    check("br_idf", bus.id_ex_flush_o, 32'd1);
    check("br_pc", bus.pc_write_o, 32'd1);
    tick(); clr();
    @(negedge clk_i);
    check("br_cnt", bus.stall_cnt_o, 32'd3);

    // Reset during the second wait cycle aborts the MDU op.
    rst_pulse();
    bus.ex_mdu_i = 1'b1;
    tick();
    tick(); rst_i = 1'b1;
    @(negedge clk_i);
    check("abort_busy", bus.mdu_busy_o, 32'd0);
    check("abort_cnt", bus.stall_cnt_o, 32'd0);
    tick(); rst_i = 1'b0; bus.ex_mdu_i = 1'b0;
    for (int k = 0; k < LAT; k++) begin
      @(negedge clk_i);
      check("abort_done", bus.mdu_done_o, 32'd0);
      check("abort_pc", bus.pc_write_o, 32'd1);
      check("abort_cnt2", bus.stall_cnt_o, 32'd0);
      tick();
    end

    // Randomized traffic, small register range to provoke matches.
    for (int i = 0; i < 3000; i++) begin
      rst_i = ($urandom_range(0, 199) == 0);
      bus.id_rs1_i = 5'($urandom_range(0, 3));
      bus.id_rs2_i = 5'($urandom_range(0, 3));
      bus.ex_rd_i  = 5'($urandom_range(0, 3));
      bus.id_uses_rs1_i = 1'($urandom_range(0, 1));
      bus.id_uses_rs2_i = 1'($urandom_range(0, 1));
      bus.ex_mem_read_i = 1'($urandom_range(0, 1));
      bus.ex_mdu_i = ($urandom_range(0, 5) == 0);
      bus.ex_branch_taken_i = ($urandom_range(0, 6) == 0);
      tick();
    end
    rst_i = 1'b0;

    // Saturation: continuous load-use for more than 65535 cycles.
    rst_pulse();
    bus.ex_mem_read_i = 1'b1; bus.ex_rd_i = 5'd3; bus.id_rs1_i = 5'd3; bus.id_uses_rs1_i = 1'b1;
    repeat (65540) tick();
    clr();
    @(negedge clk_i);
    check("sat_cnt", bus.stall_cnt_o, 32'h0000FFFF);
    tick();
    @(negedge clk_i);
    check("sat_hold", bus.stall_cnt_o, 32'h0000FFFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
